// File: rtl/uart_err_status.sv
// UART receive-path error checker: masks and checks each decoded frame, holds it in a
// one-entry valid/ready register, and keeps sticky error flags plus saturating counters.
module uart_err_status #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frm_valid,
  input  logic [DATA_W-1:0] frm_data,
  input  logic              frm_start,
  input  logic              frm_parity,
  input  logic [1:0]        frm_stop,
  input  logic [3:0]        cfg_data_bits,
  input  logic [2:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              clr_sticky,
  input  logic              clr_cnt,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_err,
  output logic [4:0]        sticky_err,
  output logic [CNT_W-1:0]  cnt_parity,
  output logic [CNT_W-1:0]  cnt_frame,
  output logic [CNT_W-1:0]  cnt_break,
  output logic [CNT_W-1:0]  cnt_overrun
);

  localparam logic [3:0]       DATA_W4 = 4'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]        eff_bits;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] data_m;
  logic              parity_err;
  logic              start_err;
  logic              stop_err;
  logic              brk;
  logic              accept;
  logic              overrun;
  logic [3:0]        frm_err;

  always_comb begin
    eff_bits = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= DATA_W4)) ? cfg_data_bits : DATA_W4;
    data_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_mask[i] = (4'(i) < eff_bits);
    end
    data_m = frm_data & data_mask;
  end

  always_comb begin
    unique case (cfg_parity)
      3'b000:  parity_err = 1'b0;
      3'b001:  parity_err = ~(^data_m ^ frm_parity);
      3'b010:  parity_err = ^data_m ^ frm_parity;
      3'b011:  parity_err = ~frm_parity;
      3'b100:  parity_err = frm_parity;
      default: parity_err = 1'b1;
    endcase
  end

  // Break: an all-zero line, including every bit the current config actually samples.
  assign brk = (data_m == '0) && !frm_start
             && ((cfg_parity == 3'b000) || !frm_parity)
             && !frm_stop[0] && (!cfg_stop2 || !frm_stop[1]);

  assign start_err = frm_start;
  assign stop_err  = !frm_stop[0] || (cfg_stop2 && !frm_stop[1]) || brk;
  assign frm_err   = {brk, stop_err, start_err, parity_err};

  assign accept  = frm_valid && (!out_valid || out_ready);
  assign overrun = frm_valid && out_valid && !out_ready;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (inc) return clr ? CNT_W'(1) : ((c == CNT_MAX) ? c : c + CNT_W'(1));
    return clr ? '0 : c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= '0;
      sticky_err  <= '0;
      cnt_parity  <= '0;
      cnt_frame   <= '0;
      cnt_break   <= '0;
      cnt_overrun <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_m;
        out_err   <= frm_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A set in the same cycle as clr_sticky wins for that bit.
      sticky_err <= (clr_sticky ? 5'b0 : sticky_err)
                  | {overrun, (accept ? frm_err : 4'b0)};
      cnt_parity  <= cnt_next(cnt_parity,  accept && parity_err,              clr_cnt);
      cnt_frame   <= cnt_next(cnt_frame,   accept && (start_err || stop_err), clr_cnt);
      cnt_break   <= cnt_next(cnt_break,   accept && brk,                     clr_cnt);
      cnt_overrun <= cnt_next(cnt_overrun, overrun,                           clr_cnt);
    end
  end

endmodule

// File: tb/tb_uart_err_status.sv
// Directed bench for uart_err_status (DATA_W=8, CNT_W=2 so saturation is reachable quickly).
module tb_uart_err_status;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frm_valid;
  logic [DATA_W-1:0] frm_data;
  logic              frm_start;
  logic              frm_parity;
  logic [1:0]        frm_stop;
  logic [3:0]        cfg_data_bits;
  logic [2:0]        cfg_parity;
  logic              cfg_stop2;
  logic              clr_sticky;
  logic              clr_cnt;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_err;
  logic [4:0]        sticky_err;
  logic [CNT_W-1:0]  cnt_parity;
  logic [CNT_W-1:0]  cnt_frame;
  logic [CNT_W-1:0]  cnt_break;
  logic [CNT_W-1:0]  cnt_overrun;

  int checks = 0;
  int errors = 0;

  uart_err_status #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_start(frm_start),
    .frm_parity(frm_parity), .frm_stop(frm_stop),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .sticky_err(sticky_err), .cnt_parity(cnt_parity), .cnt_frame(cnt_frame),
    .cnt_break(cnt_break), .cnt_overrun(cnt_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for a single cycle; clear pulses set beforehand are dropped afterwards.
  task automatic send(input logic [7:0] d, input logic s, input logic p, input logic [1:0] st,
                      input logic [3:0] bits, input logic [2:0] mode, input logic st2);
    frm_valid = 1'b1; frm_data = d; frm_start = s; frm_parity = p; frm_stop = st;
    cfg_data_bits = bits; cfg_parity = mode; cfg_stop2 = st2;
    step();
    frm_valid = 1'b0; clr_cnt = 1'b0; clr_sticky = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; frm_valid = 1'b0; frm_data = '0; frm_start = 1'b0; frm_parity = 1'b0;
    frm_stop = 2'b11; cfg_data_bits = 4'd8; cfg_parity = 3'b000; cfg_stop2 = 1'b0;
    clr_sticky = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sticky", sticky_err, 0);
    step();
    reset_n = 1'b1;
    step();

    // clean 8N1
    send(8'hA5, 0, 0, 2'b01, 8, 3'b000, 0);
    chk("clean_valid", out_valid, 1);
    chk("clean_data", out_data, 8'hA5);
    chk("clean_err", out_err, 4'b0000);
    chk("clean_cnts", {cnt_parity, cnt_frame, cnt_break, cnt_overrun}, 0);
    step();
    chk("clean_pop", out_valid, 0);

    // parity modes on 0x07, back-to-back
    send(8'h07, 0, 0, 2'b11, 8, 3'b001, 0);
    chk("odd_p0", out_err, 4'b0000);
    send(8'h07, 0, 0, 2'b11, 8, 3'b010, 0);
    chk("even_p0", out_err, 4'b0001);
    chk("even_cnt", cnt_parity, 1);
    chk("b2b_valid", out_valid, 1);
    send(8'h07, 0, 1, 2'b11, 8, 3'b011, 0);
    chk("mark_p1", out_err, 4'b0000);
    send(8'h07, 0, 1, 2'b11, 8, 3'b100, 0);
    chk("space_p1", out_err, 4'b0001);
    send(8'h07, 0, 1, 2'b11, 8, 3'b110, 0);
    chk("inval_mode", out_err, 4'b0001);
    chk("par_cnt3", cnt_parity, 3);
    chk("par_sticky", sticky_err, 5'b00001);
    step();

    clr_cnt = 1'b1; clr_sticky = 1'b1;
    step();
    clr_cnt = 1'b0; clr_sticky = 1'b0;
    chk("clr_cnt", cnt_parity, 0);
    chk("clr_sticky", sticky_err, 0);

    // width mask
    send(8'hFF, 0, 1, 2'b11, 5, 3'b010, 0);
    chk("n5_data", out_data, 8'h1F);
    chk("n5_err", out_err, 4'b0000);
    send(8'hFF, 0, 0, 2'b11, 12, 3'b000, 0);
    chk("n12_data", out_data, 8'hFF);

    // break and two stop bits
    send(8'h00, 0, 0, 2'b00, 8, 3'b010, 1);
    chk("brk_err", out_err, 4'b1100);
    chk("brk_cnt", cnt_break, 1);
    chk("brk_frame", cnt_frame, 1);
    chk("brk_sticky", sticky_err, 5'b01100);
    send(8'h55, 0, 0, 2'b10, 8, 3'b010, 1);
    chk("stop2_err", out_err, 4'b0100);
    chk("stop2_frame", cnt_frame, 2);
    send(8'h55, 0, 0, 2'b01, 8, 3'b010, 1);
    chk("stop2b_err", out_err, 4'b0100);
    chk("stop2b_frame", cnt_frame, 3);
    step();
    chk("drain", out_valid, 0);

    // overrun
    out_ready = 1'b0;
    send(8'h11, 0, 0, 2'b11, 8, 3'b000, 0);
    chk("ovr_first", out_data, 8'h11);
    send(8'h22, 1, 0, 2'b00, 8, 3'b000, 0);
    chk("ovr_hold_data", out_data, 8'h11);
    chk("ovr_hold_err", out_err, 4'b0000);
    chk("ovr_sticky", sticky_err, 5'b11100);
    chk("ovr_cnt", cnt_overrun, 1);
    chk("ovr_frame_unch", cnt_frame, 3);
    chk("ovr_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("ovr_pop", out_valid, 0);

    // saturation and clear-with-increment
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h07, 0, 0, 2'b11, 8, 3'b010, 0);
    chk("sat_parity", cnt_parity, 3);
    clr_cnt = 1'b1;
    send(8'h07, 0, 0, 2'b11, 8, 3'b010, 0);
    chk("clr_inc", cnt_parity, 1);
    chk("clr_other", cnt_overrun, 0);

    // clr_sticky coincident with start_err
    clr_sticky = 1'b1;
    send(8'h33, 1, 0, 2'b01, 8, 3'b000, 0);
    chk("clr_vs_set", sticky_err, 5'b00010);

    // async reset while holding a frame
    out_ready = 1'b0;
    send(8'h5A, 0, 0, 2'b11, 8, 3'b000, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    chk("async_err", out_err, 0);
    chk("async_sticky", sticky_err, 0);
    chk("async_cnts", {cnt_parity, cnt_frame, cnt_break, cnt_overrun}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
